timer_multi: RTL and testbench

TIMER_MULTI -- requirements
Module: timer_multi

---
 rtl/timer_multi.sv | 160 ++++++++++++++++
 tb/tb_timer_multi.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: N_CH independent 2*DATA_W-bit timer channels sharing one
// prescaler. The prescaler emits a registered one-cycle tick every
// prescale+1 clk cycles. Each channel counts ticks while enabled, can be
// cleared, and captures its count into value on a sample strobe.
//
// Build option: define TIMER_MULTI_CMP_EN to add per-channel compare
// match, periodic (auto-reload-to-zero) mode and sticky irq flags.
// Without it, compare/mode/irq_ack are ignored, every channel free-runs
// and irq is tied low.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   prescale [PRESC_W]    tick period minus one
//   enable/clear/sample   per-channel count enable, counter clear, capture
//   mode                  per-channel 0 = free-run, 1 = periodic
//   compare [N_CH*2*DW]   per-channel match value, channel i at [i*2*DW +: 2*DW]
//   irq_ack               per-channel irq acknowledge
//   value [N_CH*2*DW]     per-channel captured count, same packing as compare
//   irq                   per-channel sticky match flag
//   tick                  registered prescaler tick

module timer_multi_ch #(
   parameter int CW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_i,
   input  logic          enable_i,
   input  logic          clear_i,
   input  logic          sample_i,
   input  logic          mode_i,
   input  logic [CW-1:0] compare_i,
   input  logic          irq_ack_i,
   output logic [CW-1:0] value_o,
   output logic          irq_o
);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] value_q, value_d;
   logic          adv;

   assign adv = tick_i & enable_i;

`ifdef TIMER_MULTI_CMP_EN
   logic match;
   logic irq_q, irq_d;

   // Match looks at the pre-update count, so a periodic channel spends one
   // full tick at the compare value before reloading to zero.
   assign match = adv & (cnt_q == compare_i);

   always_comb begin
      irq_d = irq_q;
      if (irq_ack_i) irq_d = 1'b0;
      if (match)     irq_d = 1'b1;   // set beats a simultaneous ack
   end

   always_ff @(posedge clk) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end

   assign irq_o = irq_q;
`else
   logic unused_cmp;
   assign unused_cmp = ^{mode_i, compare_i, irq_ack_i};
   assign irq_o      = 1'b0;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (adv) begin
`ifdef TIMER_MULTI_CMP_EN
         if (mode_i && match) cnt_d = '0;
         else                 cnt_d = cnt_q + CW'(1);
`else
         cnt_d = cnt_q + CW'(1);
`endif
      end
   end

   // Capture uses the pre-update count, so sample+clear yields the old value.
   assign value_d = sample_i ? cnt_q : value_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         value_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         value_q <= value_d;
      end
   end

   assign value_o = value_q;
endmodule

module timer_multi #(
   parameter int DATA_W  = 32,
   parameter int N_CH    = 2,
   parameter int PRESC_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PRESC_W-1:0]       prescale,
   input  logic [N_CH-1:0]          enable,
   input  logic [N_CH-1:0]          clear,
   input  logic [N_CH-1:0]          sample,
   input  logic [N_CH-1:0]          mode,
   input  logic [N_CH*2*DATA_W-1:0] compare,
   input  logic [N_CH-1:0]          irq_ack,
   output logic [N_CH*2*DATA_W-1:0] value,
   output logic [N_CH-1:0]          irq,
   output logic                     tick
);
   localparam int CW = 2 * DATA_W;

   logic [PRESC_W-1:0] pc_q, pc_d;
   logic               tick_q, tick_d;

   // >= rather than == so that lowering prescale mid-count wraps promptly.
   always_comb begin
      if (pc_q >= prescale) begin
         pc_d   = '0;
         tick_d = 1'b1;
      end else begin
         pc_d   = pc_q + PRESC_W'(1);
         tick_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_multi_ch #(.CW(CW)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (tick_q),
         .enable_i  (enable[i]),
         .clear_i   (clear[i]),
         .sample_i  (sample[i]),
         .mode_i    (mode[i]),
         .compare_i (compare[i*CW +: CW]),
         .irq_ack_i (irq_ack[i]),
         .value_o   (value[i*CW +: CW]),
         .irq_o     (irq[i])
      );
   end
endmodule

// File: tb/tb_timer_multi.sv
module tb_timer_multi;
   localparam int DW   = 4;
   localparam int NC   = 2;
   localparam int PW   = 4;
   localparam int CW   = 2 * DW;
   localparam int CMAX = 1 << CW;
`ifdef TIMER_MULTI_CMP_EN
   localparam int CMP_EN = 1;
`else
   localparam int CMP_EN = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [PW-1:0]     prescale;
   logic [NC-1:0]     enable, clear, sample, mode, irq_ack;
   logic [NC*CW-1:0]  compare, value;
   logic [NC-1:0]     irq;
   logic              tick;

   always #5 clk = ~clk;

   timer_multi #(.DATA_W(DW), .N_CH(NC), .PRESC_W(PW)) dut (
      .clk(clk), .rst(rst), .prescale(prescale), .enable(enable),
      .clear(clear), .sample(sample), .mode(mode), .compare(compare),
      .irq_ack(irq_ack), .value(value), .irq(irq), .tick(tick)
   );

   int n_chk = 0, n_fail = 0;

   // reference state: prescaler phase, tick, per-channel count/capture/flag
   int m_pc, m_tick;
   int m_cnt[NC], m_val[NC], m_irq[NC];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one clk using the currently driven inputs, then compare outputs
   task automatic step();
      int n_pc, n_tick;
      int n_cnt[NC], n_val[NC], n_irq[NC];
      if (rst) begin
         n_pc = 0; n_tick = 0;
         for (int i = 0; i < NC; i++) begin n_cnt[i] = 0; n_val[i] = 0; n_irq[i] = 0; end
      end else begin
         if (m_pc >= int'(prescale)) begin n_pc = 0; n_tick = 1; end
         else begin n_pc = m_pc + 1; n_tick = 0; end
         for (int i = 0; i < NC; i++) begin
            bit adv, hit;
            adv = (m_tick == 1) && enable[i];
            hit = (CMP_EN == 1) && adv && (m_cnt[i] == int'(compare[i*CW +: CW]));
            n_val[i] = sample[i] ? m_cnt[i] : m_val[i];
            if (clear[i])                       n_cnt[i] = 0;
            else if (adv && mode[i] && hit)     n_cnt[i] = 0;
            else if (adv)                       n_cnt[i] = (m_cnt[i] + 1) % CMAX;
            else                                n_cnt[i] = m_cnt[i];
            n_irq[i] = hit ? 1 : (irq_ack[i] ? 0 : m_irq[i]);
         end
      end
      @(posedge clk); #1;
      m_pc = n_pc; m_tick = n_tick;
      for (int i = 0; i < NC; i++) begin
         m_cnt[i] = n_cnt[i]; m_val[i] = n_val[i]; m_irq[i] = n_irq[i];
      end
      chk("tick", 32'(tick), m_tick);
      for (int i = 0; i < NC; i++) begin
         chk($sformatf("value%0d", i), 32'(value[i*CW +: CW]), m_val[i]);
         chk($sformatf("irq%0d", i), 32'(irq[i]), m_irq[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int nt, k;
      rst = 1'b1; prescale = '0; enable = '0; clear = '0; sample = '0;
      mode = '0; irq_ack = '0; compare = '1;
      m_pc = 0; m_tick = 0;
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_val[i] = 0; m_irq[i] = 0; end
      step(); step();
      chk("rst_value", 32'(value), 0);
      rst = 1'b0;

      // prescale 3: tick every 4th cycle, five counted ticks in 24 cycles
      prescale = 4'd3; enable = 2'b01; nt = 0;
      repeat (24) begin step(); nt += int'(tick); end
      chk("tick_cnt", nt, 6);
      enable = '0; sample = 2'b01; step();
      chk("presc_val", 32'(value[7:0]), 5);
      sample = '0;

      // periodic, compare 4, sampled every cycle
      rst = 1'b1; step(); rst = 1'b0;
      prescale = '0; mode = 2'b01; compare[7:0] = 8'd4; enable = 2'b01; sample = 2'b01;
      repeat (14) step();
      enable = '0; repeat (3) step();
      chk("irq_hold", 32'(irq[0]), CMP_EN);
      irq_ack = 2'b01; step(); irq_ack = '0;
      chk("irq_acked", 32'(irq[0]), 0);
      sample = '0;

      // free-run wrap: ch0 compare 0x10 (no irq at wrap), ch1 compare 0xFF
      clear = 2'b11; step(); clear = '0;
      mode = '0; compare = {8'hFF, 8'h10}; enable = 2'b11;
      k = 0;
      while (m_cnt[0] != 255 && k < 300) begin step(); k++; end
      chk("wrap_reach", 32'(m_cnt[0]), 255);
      enable = '0; irq_ack = 2'b11; step(); irq_ack = '0;
      enable = 2'b11; sample = 2'b11; step();
      chk("wrap_pre", 32'(value[7:0]), 255);
      enable = '0; step();
      chk("wrap_val", 32'(value[7:0]), 0);
      chk("wrap_irq0", 32'(irq[0]), 0);
      chk("wrap_irq1", 32'(irq[1]), CMP_EN);
      sample = '0; irq_ack = 2'b11; step(); irq_ack = '0;

      // sample and clear together at cnt 9
      clear = 2'b01; step(); clear = '0; enable = 2'b01; k = 0;
      while (m_cnt[0] != 9 && k < 40) begin step(); k++; end
      enable = '0; sample = 2'b01; clear = 2'b01; step();
      chk("sc_val", 32'(value[7:0]), 9);
      clear = '0; step();
      chk("sc_cnt", 32'(value[7:0]), 0);
      sample = '0;

      // match coinciding with ack: set wins
      mode = 2'b01; compare[7:0] = 8'd3; irq_ack = 2'b01; enable = 2'b01; k = 0;
      while (m_cnt[0] != 3 && k < 40) begin step(); k++; end
      step();
      chk("set_wins", 32'(irq[0]), CMP_EN);
      enable = '0; step();
      irq_ack = '0;

      // reset mid-count restarts prescaler phase
      prescale = 4'd3; mode = '0; enable = 2'b01; k = 0;
      while (!(m_pc == 2 && m_cnt[0] >= 2) && k < 60) begin step(); k++; end
      rst = 1'b1; step();
      chk("rst_tick", 32'(tick), 0);
      chk("rst_val", 32'(value), 0);
      chk("rst_irq", 32'(irq), 0);
      rst = 1'b0; k = 0;
      do begin step(); k++; end while (!tick && k < 10);
      chk("first_tick", k, 4);

      // randomized traffic
      repeat (600) begin
         if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NC; i++) begin
            enable[i]  = ($urandom_range(0, 3) != 0);
            clear[i]   = ($urandom_range(0, 24) == 0);
            sample[i]  = ($urandom_range(0, 2) == 0);
            irq_ack[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) mode[i] = ~mode[i];
            if ($urandom_range(0, 29) == 0) compare[i*CW +: CW] = CW'($urandom_range(0, 12));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
